// File: rtl/clint_rtc_tick_pkg.sv
// Shared widths and source-select encoding for the CLINT real-time tick generator.
package clint_rtc_tick_pkg;

  localparam int CLINT_RTC_DIV_WIDTH  = 16;
  localparam int CLINT_RTC_TMO_WIDTH  = 16;
  localparam int CLINT_RTC_PSCR_WIDTH = 8;

  typedef enum logic {
    SRC_EXT = 1'b0,
    SRC_INT = 1'b1
  } rtc_src_e;

endpackage

// File: rtl/clint_sync_filter.sv
// Synchronizes an asynchronous level, accepts a new level only after it persists
// FILT_LEN cycles, and emits a one-cycle pulse on each accepted rising edge.
module clint_sync_filter
  import clint_rtc_tick_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  localparam int CNT_W = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   filt_prev_q, filt_prev_d;
  logic                   sync_lvl;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], async_i};
    sync_lvl    = sync_q[SYNC_STAGES-1];
    filt_d      = filt_q;
    filt_prev_d = filt_q;
    cnt_d       = '0;
    // The counter only survives while the level keeps disagreeing; any agreeing sample restarts it.
    if (sync_lvl != filt_q) begin
      if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
        filt_d = sync_lvl;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
    end
  end

  assign rise_o = filt_q & ~filt_prev_q;

endmodule

// File: rtl/clint_rtc_tick.sv
// Real-time tick generator for the CLINT mtime increment: qualifies the low-speed clock
// (or an internal divider), prescales it, and flags a stalled low-speed clock.
module clint_rtc_tick
  import clint_rtc_tick_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int DIV_WIDTH   = CLINT_RTC_DIV_WIDTH,
  parameter int TMO_WIDTH   = CLINT_RTC_TMO_WIDTH
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            en_i,
  input  logic                            sel_int_i,
  input  logic [DIV_WIDTH-1:0]            div_i,
  input  logic [CLINT_RTC_PSCR_WIDTH-1:0] pscr_i,
  input  logic [TMO_WIDTH-1:0]            tmo_i,
  input  logic                            low_clk_i,
  input  logic                            lost_clr_i,
  output logic                            tick_o,
  output logic                            lost_o
);

  rtc_src_e                        src_sel;
  logic                            rise, int_edge, src, sel_change, wd_active, lost_set;
  logic                            sel_q;
  logic [DIV_WIDTH-1:0]            dcnt_q, dcnt_d;
  logic [CLINT_RTC_PSCR_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [TMO_WIDTH-1:0]            tcnt_q, tcnt_d;
  logic                            tick_q, tick_d;
  logic                            lost_q, lost_d;

  clint_sync_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_sync_filter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .async_i(low_clk_i),
    .rise_o (rise)
  );

  always_comb begin
    src_sel    = rtc_src_e'(sel_int_i);
    sel_change = (sel_int_i != sel_q);
    int_edge   = en_i && (dcnt_q >= div_i);
    src        = (src_sel == SRC_INT) ? int_edge : rise;
    wd_active  = en_i && (src_sel == SRC_EXT) && (tmo_i != '0);
    lost_set   = wd_active && (tcnt_q == tmo_i);
    dcnt_d     = '0;
    pcnt_d     = '0;
    tcnt_d     = '0;
    tick_d     = 1'b0;
    // A source switch restarts every count so a half-finished period of one source never leaks into the other.
    if (en_i && !sel_change) begin
      dcnt_d = int_edge ? '0 : dcnt_q + 1'b1;
      pcnt_d = pcnt_q;
      if (src) begin
        if (pcnt_q >= pscr_i) begin
          pcnt_d = '0;
          tick_d = 1'b1;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      if (wd_active && !rise) begin
        tcnt_d = (tcnt_q == '1) ? tcnt_q : tcnt_q + 1'b1;
      end
    end
    lost_d = lost_set ? 1'b1 : (lost_clr_i ? 1'b0 : lost_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dcnt_q <= '0;
      pcnt_q <= '0;
      tcnt_q <= '0;
      tick_q <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      dcnt_q <= dcnt_d;
      pcnt_q <= pcnt_d;
      tcnt_q <= tcnt_d;
      tick_q <= tick_d;
      lost_q <= lost_d;
    end
  end

  // Follows the select even through reset, so leaving reset is never mistaken for a source switch.
  always_ff @(posedge clk_i) begin
    sel_q <= sel_int_i;
  end

  assign tick_o = tick_q;
  assign lost_o = lost_q;

endmodule
